// File: rtl/pe_mac_ctrl_if.sv
// Operand/result handshake bundle for pe_mac_ctrl.
//   in_valid/in_ready   : operand pair handshake (in_neuron, in_weight = 32 x int16 each)
//   out_valid/out_ready : result handshake (out_data = signed ACC_W-bit dot product)
// master: operand producer / result consumer side.  slave: the controller.
interface pe_mac_ctrl_if #(
  parameter int ACC_W = 48
);
  logic             in_valid;
  logic             in_ready;
  logic [511:0]     in_neuron;
  logic [511:0]     in_weight;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport master (
    output in_valid, in_neuron, in_weight, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_neuron, in_weight, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pe_mac_ctrl.sv
// pe_mac_ctrl: streams vec_num neuron/weight vector pairs into the external
// pe_mult, sums the 32 int32 lane products of each pair and accumulates them
// into one signed dot-product result returned over a valid/ready handshake.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, vec_num    : job start (IDLE only) and pair count, latched on start
//   busy, done        : not-IDLE flag, one-cycle pulse on result acceptance
//   io (slave)        : operand input and result output handshakes
//   mult_neuron/weight: registered operands driven to pe_mult
//   mult_result       : 32 x int32 products returned by pe_mult (same cycle)
module pe_mac_ctrl #(
  parameter int VEC_NUM_W = 16,
  parameter int ACC_W     = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [VEC_NUM_W-1:0] vec_num,
  output logic                 busy,
  output logic                 done,
  pe_mac_ctrl_if.slave         io,
  output logic [511:0]         mult_neuron,
  output logic [511:0]         mult_weight,
  input  logic [1023:0]        mult_result
);

  localparam int LANES = 32;
  localparam int SUM_W = 37;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  state_t                   state, state_nxt;
  logic [VEC_NUM_W-1:0]     issue_cnt;
  logic [VEC_NUM_W-1:0]     retire_cnt;
  logic                     vld_p1;
  logic                     vld_p2;
  logic signed [SUM_W-1:0]  sum_p2;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]         out_data_r;
  logic                     in_ready_c;
  logic                     hs;
  logic                     last_ret;
  logic                     job_go;

  // Exact sum of 32 sign-extended int32 lanes; 37 bits cannot overflow.
  function automatic logic signed [SUM_W-1:0] sum_lanes(input logic [1023:0] p);
    logic signed [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      s = s + {{(SUM_W-32){p[i*32+31]}}, p[i*32 +: 32]};
    end
    return s;
  endfunction

  // Sign-extend a lane sum into the accumulator and add with natural wrap.
  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [SUM_W-1:0] s);
    return a + {{(ACC_W-SUM_W){s[SUM_W-1]}}, s};
  endfunction

  assign acc_next     = acc_add(acc, sum_p2);
  assign busy         = (state != IDLE);
  assign io.in_ready  = in_ready_c;
  assign io.out_valid = (state == HOLD);
  assign io.out_data  = out_data_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    hs         = 1'b0;
    job_go     = 1'b0;
    last_ret   = vld_p2 && (retire_cnt == VEC_NUM_W'(1));
    case (state)
      IDLE: begin
        if (start) begin
          job_go    = (vec_num != '0);
          state_nxt = job_go ? RUN : HOLD;
        end
      end
      RUN: begin
        in_ready_c = (issue_cnt != '0);
        hs         = in_ready_c && io.in_valid;
        if (hs && issue_cnt == VEC_NUM_W'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_ret) state_nxt = HOLD;
      end
      HOLD: begin
        if (io.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt   <= '0;
      retire_cnt  <= '0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      sum_p2      <= '0;
      acc         <= '0;
      out_data_r  <= '0;
      mult_neuron <= '0;
      mult_weight <= '0;
      done        <= 1'b0;
    end else begin
      done <= (state == HOLD) && io.out_ready;

      if (job_go) begin
        issue_cnt  <= vec_num;
        retire_cnt <= vec_num;
        acc        <= '0;
      end else if (state == IDLE && start) begin
        out_data_r <= '0;
      end

      // Stage p0 -> p1: operand capture; mult_* hold when no handshake.
      vld_p1 <= hs;
      if (hs) begin
        mult_neuron <= io.in_neuron;
        mult_weight <= io.in_weight;
        issue_cnt   <= issue_cnt - VEC_NUM_W'(1);
      end

      // Stage p1 -> p2: lane reduction, only for freshly captured operands.
      vld_p2 <= vld_p1;
      if (vld_p1) sum_p2 <= sum_lanes(mult_result);

      // Stage p2 -> accumulator: accumulate and retire; last retire publishes.
      if (vld_p2) begin
        acc        <= acc_next;
        retire_cnt <= retire_cnt - VEC_NUM_W'(1);
        if (last_ret) out_data_r <= acc_next;
      end
    end
  end

endmodule
